// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl
// Description : Time-of-day counter with a stop/run/set mode FSM driven by
//               single-cycle key pulses and a one-pulse-per-second tick.
// Revision    : 1.0  initial release
// ============================================================================
module clock_ctrl #(
  parameter int HOURS = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_key_mode,
  input  logic       i_key_run,
  input  logic       i_key_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic       o_day_pulse
);

  localparam logic [1:0] c_STOP     = 2'b00;
  localparam logic [1:0] c_RUN      = 2'b01;
  localparam logic [1:0] c_SET_HOUR = 2'b10;
  localparam logic [1:0] c_SET_MIN  = 2'b11;
  localparam logic [5:0] c_SM_MAX   = 6'd59;
  localparam logic [4:0] c_HOUR_MAX = 5'(HOURS - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic       r_day;

  logic w_ev_mode, w_ev_run, w_ev_inc, w_ev_tick;
  logic w_adv_sec, w_inc_min, w_inc_hour, w_clr_sec;
  logic w_sec_wrap, w_min_wrap, w_hour_wrap;
  logic [5:0] w_sec_inc, w_min_inc;
  logic [4:0] w_hour_inc;

  // Only the highest-priority asserted event survives; the rest are dropped.
  assign w_ev_mode = i_key_mode;
  assign w_ev_run  = i_key_run & ~i_key_mode;
  assign w_ev_inc  = i_key_inc & ~i_key_run & ~i_key_mode;
  assign w_ev_tick = i_tick & ~i_key_inc & ~i_key_run & ~i_key_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_STOP;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_ev_mode) begin
      case (r_state)
        c_STOP, c_RUN: w_state_nxt = c_SET_HOUR;
        c_SET_HOUR:    w_state_nxt = c_SET_MIN;
        default:       w_state_nxt = c_RUN;
      endcase
    end else if (w_ev_run) begin
      case (r_state)
        c_STOP:  w_state_nxt = c_RUN;
        c_RUN:   w_state_nxt = c_STOP;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_adv_sec  = w_ev_tick && (r_state == c_RUN);
    w_inc_hour = w_ev_inc  && (r_state == c_SET_HOUR);
    w_inc_min  = w_ev_inc  && (r_state == c_SET_MIN);
    w_clr_sec  = w_ev_mode && (r_state == c_SET_MIN);
  end

  // ">=" folds any out-of-range value onto the wrap path.
  assign w_sec_wrap  = (r_sec  >= c_SM_MAX);
  assign w_min_wrap  = (r_min  >= c_SM_MAX);
  assign w_hour_wrap = (r_hour >= c_HOUR_MAX);
  assign w_sec_inc   = w_sec_wrap  ? 6'd0 : r_sec  + 6'd1;
  assign w_min_inc   = w_min_wrap  ? 6'd0 : r_min  + 6'd1;
  assign w_hour_inc  = w_hour_wrap ? 5'd0 : r_hour + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= 5'd0;
      r_day  <= 1'b0;
    end else begin
      r_day <= 1'b0;
      if (w_clr_sec) begin
        r_sec <= 6'd0;
      end else if (w_adv_sec) begin
        r_sec <= w_sec_inc;
        if (w_sec_wrap) begin
          r_min <= w_min_inc;
          if (w_min_wrap) begin
            r_hour <= w_hour_inc;
            r_day  <= w_hour_wrap;
          end
        end
      end else if (w_inc_min) begin
        r_min <= w_min_inc;
      end else if (w_inc_hour) begin
        r_hour <= w_hour_inc;
      end
    end
  end

  assign o_sec       = r_sec;
  assign o_min       = r_min;
  assign o_hour      = r_hour;
  assign o_mode      = r_state;
  assign o_day_pulse = r_day;

endmodule
`default_nettype wire

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter: HOURS, default 24, hour-field modulus (legal 12 or 24).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle time-base enable, one pulse per counted second.
REQ-005 key_mode  input  1  one-cycle pulse, debounced upstream; steps the mode FSM.
REQ-006 key_run  input  1  one-cycle pulse, debounced upstream; toggles stopped/running.
REQ-007 key_inc  input  1  one-cycle pulse, debounced upstream; increments the field selected for setting.
REQ-008 sec  output  6  seconds field, 0..59, registered.
REQ-009 min  output  6  minutes field, 0..59, registered.
REQ-010 hour  output  5  hours field, 0..HOURS-1, registered.
REQ-011 mode  output  2  current FSM state: 00 STOP, 01 RUN, 10 SET_HOUR, 11 SET_MIN.
REQ-012 day_pulse  output  1  one-cycle pulse on hour-field wrap.

Function
REQ-013 FSM states SHALL be STOP, RUN, SET_HOUR and SET_MIN, with registered state.
REQ-014 key_mode SHALL move STOP->SET_HOUR, RUN->SET_HOUR, SET_HOUR->SET_MIN and SET_MIN->RUN.
REQ-015 key_run SHALL move STOP->RUN and RUN->STOP, and SHALL be ignored in SET_HOUR and SET_MIN.
REQ-016 Event priority in one cycle SHALL be key_mode > key_run > key_inc > tick; only the highest-priority asserted event SHALL take effect and the others SHALL be dropped.
REQ-017 tick SHALL advance time only in RUN; in STOP, SET_HOUR and SET_MIN it SHALL be ignored, with no accumulation.
REQ-018 Run-time increment: sec 0..58 SHALL increment by 1; sec 59 SHALL become 0 and carry into min.
REQ-019 min 59 with an incoming carry SHALL become 0 and carry into hour.
REQ-020 hour HOURS-1 with an incoming carry SHALL become 0 and assert day_pulse for exactly the following cycle.
REQ-021 All field updates from one tick SHALL occur on the same edge; for example, 23:59:59 -> 00:00:00 appears on one edge.
REQ-022 Latency: tick sampled at edge n SHALL make the new fields visible after edge n, i.e. in cycle n+1.
REQ-023 In SET_HOUR, key_inc SHALL increment hour modulo HOURS, with no carry and no day_pulse.
REQ-024 In SET_MIN, key_inc SHALL increment min modulo 60, with no carry into hour.
REQ-025 In STOP and RUN, key_inc SHALL be ignored.
REQ-026 The SET_MIN->RUN transition SHALL clear sec to 0 on the same edge.
REQ-027 All other transitions SHALL leave sec, min and hour unchanged.
REQ-028 Fields SHALL never hold out-of-range values; any out-of-range value reached SHALL be treated as the wrap value on its next increment.
REQ-029 day_pulse SHALL be 0 in every cycle not covered by REQ-020.
REQ-030 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-031 While rst_n=0: sec=0, min=0, hour=0, mode=STOP (00), day_pulse=0, independent of clk.
REQ-032 Reset asserted mid-operation (any state, any field value) SHALL force REQ-031 values immediately.
REQ-033 After release, the first effective event SHALL be one sampled on a rising edge with rst_n=1; no tick or key is remembered across reset.

Verification
REQ-034 Reset, key_run, then 61 ticks -> mode=01, fields 00:01:01, day_pulse never asserted.
REQ-035 Preset 23:59:58 via SET_HOUR/SET_MIN plus ticks, RUN, then 2 ticks -> 23:59:59, then 00:00:00 with day_pulse high exactly one cycle.
REQ-036 From STOP: key_mode, 25 key_inc, key_mode, 61 key_inc, key_mode -> hour=1, min=1, sec=0, mode=01.
REQ-037 Same-cycle pairs:
- key_mode+tick in RUN -> SET_HOUR, fields unchanged.
- key_run+key_inc in STOP -> RUN, fields unchanged.
- tick in STOP -> no change.
REQ-038 Running at 10:20:30, assert rst_n=0 between edges -> outputs 00:00:00, mode=00 before the next edge; ticks during reset have no effect.
REQ-039 HOURS=12 build: SET_HOUR with 12 key_inc from 0 -> hour=0; run-time wrap at 11:59:59 -> 00:00:00 with day_pulse.
